// File: rtl/cpu_icache_if.sv
// Lookup and memory-bus signals between the instruction cache and its neighbours.
// The master side drives lookups, grant and read data; the cache is the slave.
interface cpu_icache_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              en_rx;
    logic              en_ry;
    logic [ADDR_W-1:0] pcx;
    logic [ADDR_W-1:0] pcy;
    logic              hitx;
    logic              hity;
    logic [31:0]       instx;
    logic [31:0]       insty;
    logic              mem_req_out;
    logic              mem_gnt_in;
    logic [ADDR_W-1:0] mem_a_out;
    logic [7:0]        mem_din;

    modport master (
        output rdy, en_rx, en_ry, pcx, pcy, mem_gnt_in, mem_din,
        input  hitx, hity, instx, insty, mem_req_out, mem_a_out
    );

    modport slave (
        input  rdy, en_rx, en_ry, pcx, pcy, mem_gnt_in, mem_din,
        output hitx, hity, instx, insty, mem_req_out, mem_a_out
    );
endinterface

// File: rtl/cpu_icache.sv
// Direct-mapped, one-word-per-line instruction cache with two combinational lookup
// ports and a byte-serial refill over the shared memory bus (big-endian by address).
module cpu_icache #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    cpu_icache_if.slave  bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, REQ, READ} state_t;

    state_t            state, state_nxt;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [ADDR_W-1:0] fill_addr;
    logic [2:0]        k;
    logic [31:0]       buffer;
    logic              fill_ld, fill_sel_y, fill_done;
    logic              req, hitx, hity;
    logic [ADDR_W-1:0] addr;

    logic [INDEX_W-1:0] idx_x, idx_y, fill_idx;
    logic [TAG_W-1:0]   tag_x, tag_y, fill_tag;
    logic               unused_low_bits;

    assign idx_x    = bus.pcx[INDEX_W+1:2];
    assign tag_x    = bus.pcx[ADDR_W-1:INDEX_W+2];
    assign idx_y    = bus.pcy[INDEX_W+1:2];
    assign tag_y    = bus.pcy[ADDR_W-1:INDEX_W+2];
    assign fill_idx = fill_addr[INDEX_W+1:2];
    assign fill_tag = fill_addr[ADDR_W-1:INDEX_W+2];
    assign unused_low_bits = ^{bus.pcx[1:0], bus.pcy[1:0]};

    // Zero-latency lookups; they stay live while a fill is in flight.
    assign hitx = bus.en_rx & valid[idx_x] & (tag_mem[idx_x] == tag_x);
    assign hity = bus.en_ry & valid[idx_y] & (tag_mem[idx_y] == tag_y);

    assign bus.hitx        = hitx;
    assign bus.hity        = hity;
    assign bus.instx       = hitx ? data_mem[idx_x] : 32'd0;
    assign bus.insty       = hity ? data_mem[idx_y] : 32'd0;
    assign bus.mem_req_out = req;
    assign bus.mem_a_out   = addr;

    always_comb begin
        state_nxt  = state;
        fill_ld    = 1'b0;
        fill_sel_y = 1'b0;
        fill_done  = 1'b0;
        req        = 1'b0;
        addr       = '0;
        case (state)
            IDLE: begin
                if (bus.en_rx && !hitx) begin
                    fill_ld   = 1'b1;
                    state_nxt = REQ;
                end else if (bus.en_ry && !hity) begin
                    fill_ld    = 1'b1;
                    fill_sel_y = 1'b1;
                    state_nxt  = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (bus.mem_gnt_in) state_nxt = READ;
            end
            READ: begin
                req = 1'b1;
                // k=0..3 drive byte addresses; k=4 only captures the last byte.
                if (k != 3'd4) begin
                    addr = fill_addr + ADDR_W'(k);
                end else begin
                    fill_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            valid <= '0;
            k     <= '0;
        end else if (bus.rdy) begin
            state <= state_nxt;
            if (state == REQ)
                k <= '0;
            else if (state == READ)
                k <= k + 3'd1;
            if (fill_done)
                valid[fill_idx] <= 1'b1;
        end
    end

    // Line storage and refill buffer carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (bus.rdy) begin
            if (fill_ld)
                fill_addr <= fill_sel_y ? {bus.pcy[ADDR_W-1:2], 2'b00}
                                        : {bus.pcx[ADDR_W-1:2], 2'b00};
            if (state == READ) begin
                case (k)
                    3'd1: buffer[31:24] <= bus.mem_din;
                    3'd2: buffer[23:16] <= bus.mem_din;
                    3'd3: buffer[15:8]  <= bus.mem_din;
                    default: ;
                endcase
            end
            if (fill_done) begin
                tag_mem[fill_idx]  <= fill_tag;
                data_mem[fill_idx] <= {buffer[31:8], bus.mem_din};
            end
        end
    end
endmodule
